mmc3_irq_counter: RTL and testbench

MMC3_IRQ_COUNTER -- requirements
Module: mmc3_irq_counter

---
 rtl/mmc3_irq_counter.sv | 137 +++++++++++++
 tb/tb_mmc3_irq_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmc3_irq_counter.sv
// MMC3-style scanline IRQ counter: CPU register decode, filtered PPU A12 rise counting, save-state readback.
// Define MMC3_IRQ_REV_A_EN to build the Rev A zero-detect behaviour; the default build is Rev B.
module mmc3_irq_counter #(
  parameter int A12_FILT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_m2,
  input  logic       cpu_rw,
  input  logic       cpu_a15,
  input  logic       cpu_a14,
  input  logic       cpu_a13,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_data,
  input  logic       ppu_a12,
  output logic       irq_n,
  input  logic [7:0] sst_addr,
  output logic [7:0] sst_di
);

  localparam logic [2:0] FILT = 3'(A12_FILT);

  logic       m2_q;
  logic       a12_q;
  logic [2:0] low_cnt;
  logic [7:0] cnt;
  logic [7:0] latch;
  logic       reload;
  logic       en;
  logic       pending;
  logic       rise_d;
  logic       zero_ok;

  logic       m2_fall;
  logic       wr;
  logic       wr_c000;
  logic       wr_c001;
  logic       wr_e000;
  logic       wr_e001;
  logic       a12_rise;
  logic       rise_qual;
  logic       clock_cnt;
  logic       reload_take;
  logic       set_irq;
  logic [7:0] latch_nx;
  logic [7:0] cnt_nx;
  logic       reload_nx;
  logic       en_nx;
  logic       pending_nx;
  logic       zero_ok_nx;
  logic [2:0] low_cnt_nx;

  always_comb begin
    m2_fall  = m2_q & ~cpu_m2;
    wr       = m2_fall & ~cpu_rw & cpu_a15;
    wr_c000  = wr &  cpu_a14 & ~cpu_a13 & ~cpu_a0;
    wr_c001  = wr &  cpu_a14 & ~cpu_a13 &  cpu_a0;
    wr_e000  = wr &  cpu_a14 &  cpu_a13 & ~cpu_a0;
    wr_e001  = wr &  cpu_a14 &  cpu_a13 &  cpu_a0;

    a12_rise  = ~a12_q & ppu_a12;
    rise_qual = a12_rise & (low_cnt >= FILT);
    // A $C001 write on the same clk swallows the rise entirely.
    clock_cnt = rise_qual & ~wr_c001;

    latch_nx    = wr_c000 ? cpu_data : latch;
    reload_take = (cnt == 8'd0) | reload;

    cnt_nx    = cnt;
    reload_nx = reload;
    if (wr_c001) begin
      cnt_nx    = 8'd0;
      reload_nx = 1'b1;
    end else if (clock_cnt) begin
      reload_nx = 1'b0;
      if (reload_take) cnt_nx = latch_nx;
      else             cnt_nx = cnt - 8'd1;
    end

`ifdef MMC3_IRQ_REV_A_EN
    // Only a decrement from 1, or a forced reload of a zero latch, counts as reaching zero.
    zero_ok_nx = clock_cnt & (reload_take ? (reload & (latch_nx == 8'd0))
                                          : (cnt == 8'd1));
`else
    zero_ok_nx = clock_cnt;
`endif

    en_nx = en;
    if (wr_e000)      en_nx = 1'b0;
    else if (wr_e001) en_nx = 1'b1;

    set_irq    = rise_d & zero_ok & en & (cnt == 8'd0);
    pending_nx = wr_e000 ? 1'b0 : (pending | set_irq);

    low_cnt_nx = low_cnt;
    if (ppu_a12)                        low_cnt_nx = 3'd0;
    else if (m2_fall && low_cnt != 3'd7) low_cnt_nx = low_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m2_q    <= cpu_m2;
      a12_q   <= ppu_a12;
      low_cnt <= 3'd0;
      cnt     <= 8'd0;
      latch   <= 8'd0;
      reload  <= 1'b0;
      en      <= 1'b0;
      pending <= 1'b0;
      rise_d  <= 1'b0;
      zero_ok <= 1'b0;
      irq_n   <= 1'b1;
    end else begin
      m2_q    <= cpu_m2;
      a12_q   <= ppu_a12;
      low_cnt <= low_cnt_nx;
      cnt     <= cnt_nx;
      latch   <= latch_nx;
      reload  <= reload_nx;
      en      <= en_nx;
      pending <= pending_nx;
      rise_d  <= clock_cnt;
      zero_ok <= zero_ok_nx;
      irq_n   <= ~pending_nx;
    end
  end

  always_comb begin
    case (sst_addr)
      8'd0:    sst_di = cnt;
      8'd1:    sst_di = latch;
      8'd2:    sst_di = {5'b0, pending, reload, en};
      default: sst_di = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Self-checking bench for mmc3_irq_counter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mmc3_irq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_m2 = 1'b0;
  logic       cpu_rw = 1'b1;
  logic       cpu_a15 = 1'b0;
  logic       cpu_a14 = 1'b0;
  logic       cpu_a13 = 1'b0;
  logic       cpu_a0 = 1'b0;
  logic [7:0] cpu_data = 8'd0;
  logic       ppu_a12 = 1'b0;
  logic       irq_n;
  logic [7:0] sst_addr = 8'd0;
  logic [7:0] sst_di;

  localparam int FILT = 3;

  mmc3_irq_counter #(.A12_FILT(FILT)) dut (
    .clk(clk), .rst(rst), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_a15(cpu_a15), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13), .cpu_a0(cpu_a0),
    .cpu_data(cpu_data), .ppu_a12(ppu_a12), .irq_n(irq_n),
    .sst_addr(sst_addr), .sst_di(sst_di)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  // Model state: plain integers describing the architectural registers.
  int m_cnt, m_latch, m_low;
  bit m_reload, m_en, m_pend, m_m2, m_a12;
  bit m_due;  // a counter event just produced zero; IRQ fires next clk if enabled

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_sst(input int a);
    case (a)
      0:       return m_cnt;
      1:       return m_latch;
      2:       return (m_pend ? 4 : 0) + (m_reload ? 2 : 0) + (m_en ? 1 : 0);
      default: return 255;
    endcase
  endfunction

  task automatic model_step();
    bit fall, wr, c000, c001, e000, e001, qual, was_reload;
    int reg_idx;
    if (rst) begin
      m_cnt = 0; m_latch = 0; m_low = 0;
      m_reload = 0; m_en = 0; m_pend = 0; m_due = 0;
      m_m2 = cpu_m2; m_a12 = ppu_a12;
      return;
    end
    fall    = m_m2 && !cpu_m2;
    wr      = fall && !cpu_rw && cpu_a15;
    reg_idx = (cpu_a14 ? 4 : 0) + (cpu_a13 ? 2 : 0) + (cpu_a0 ? 1 : 0);
    c000 = wr && reg_idx == 4;
    c001 = wr && reg_idx == 5;
    e000 = wr && reg_idx == 6;
    e001 = wr && reg_idx == 7;
    qual = !m_a12 && ppu_a12 && m_low >= FILT;

    if (e000)                      m_pend = 0;
    else if (m_due && m_en)        m_pend = 1;
    m_due = 0;

    if (c000) m_latch = int'(cpu_data);
    if (c001) begin
      m_cnt = 0;
      m_reload = 1;
    end else if (qual) begin
      if (m_cnt == 0 || m_reload) begin
        was_reload = m_reload;
        m_cnt = m_latch;
        m_reload = 0;
`ifdef MMC3_IRQ_REV_A_EN
        m_due = was_reload && m_cnt == 0;
`else
        m_due = m_cnt == 0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
        m_due = m_cnt == 0;
      end
    end
    if (e000) m_en = 0;
    if (e001) m_en = 1;

    if (ppu_a12)   m_low = 0;
    else if (fall) m_low = (m_low < 7) ? m_low + 1 : 7;
    m_m2  = cpu_m2;
    m_a12 = ppu_a12;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("irq_n", int'(irq_n), m_pend ? 0 : 1);
    chk("sst_di", int'(sst_di), model_sst(int'(sst_addr)));
  endtask

  task automatic peek(input string name, input int a, input int exp);
    sst_addr = 8'(a);
    #1;
    chk(name, int'(sst_di), exp);
  endtask

  // reg_idx: 4=$C000 5=$C001 6=$E000 7=$E001
  task automatic cpu_wr(input int reg_idx, input int data);
    cpu_m2 = 1'b1; cpu_rw = 1'b1;
    tick();
    cpu_m2 = 1'b0; cpu_rw = 1'b0; cpu_a15 = 1'b1;
    cpu_a14 = reg_idx[2]; cpu_a13 = reg_idx[1]; cpu_a0 = reg_idx[0];
    cpu_data = 8'(data);
    tick();
    cpu_rw = 1'b1; cpu_a15 = 1'b0;
  endtask

  task automatic low_falls(input int n);
    ppu_a12 = 1'b0;
    for (int i = 0; i < n; i++) begin
      cpu_m2 = 1'b1; tick();
      cpu_m2 = 1'b0; tick();
    end
  endtask

  task automatic a12_rise();
    ppu_a12 = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_m2 = 1'b0; cpu_rw = 1'b1; cpu_a15 = 1'b0; ppu_a12 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int exp_irq;

  initial begin
    do_reset();
    chk("reset_irq_n", int'(irq_n), 1);
    peek("reset_cnt", 0, 0);

    // Basic count-down to IRQ
    cpu_wr(4, 3); cpu_wr(5, 0); cpu_wr(7, 0);
    a12_rise(); peek("cnt_rise1", 0, 3);
    low_falls(3); a12_rise(); peek("cnt_rise2", 0, 2);
    low_falls(3); a12_rise(); peek("cnt_rise3", 0, 1);
    low_falls(3); a12_rise(); peek("cnt_rise4", 0, 0);
    chk("irq_n_same_clk", int'(irq_n), 1);
    tick();
    chk("irq_n_after_rise4", int'(irq_n), 0);

    // Acknowledge, re-enable with cnt=0 and no rise
    cpu_wr(6, 0);
    chk("irq_n_after_ack", int'(irq_n), 1);
    cpu_wr(7, 0); tick(); tick(); tick();
    chk("irq_n_reenable_no_rise", int'(irq_n), 1);

    // Filter threshold
    low_falls(3); a12_rise(); peek("cnt_reload", 0, 3);
    low_falls(2); a12_rise(); peek("cnt_filt2", 0, 3);
    low_falls(3); a12_rise(); peek("cnt_filt3", 0, 2);

    // Latch=0 behaviour across revisions
    do_reset();
    cpu_wr(4, 0); cpu_wr(5, 0); cpu_wr(7, 0);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) low_falls(3);
      a12_rise(); tick();
`ifdef MMC3_IRQ_REV_A_EN
      exp_irq = (i == 0) ? 0 : 1;
`else
      exp_irq = 0;
`endif
      chk($sformatf("latch0_irq_rise%0d", i), int'(irq_n), exp_irq);
      cpu_wr(6, 0); cpu_wr(7, 0);
    end

    // $C001 coinciding with a qualified rise
    do_reset();
    cpu_wr(4, 5);
    low_falls(3); a12_rise(); peek("pre_coinc_cnt", 0, 5);
    low_falls(3);
    cpu_m2 = 1'b1; tick();
    cpu_m2 = 1'b0; cpu_rw = 1'b0; cpu_a15 = 1'b1;
    cpu_a14 = 1'b1; cpu_a13 = 1'b0; cpu_a0 = 1'b1; ppu_a12 = 1'b1;
    tick();
    cpu_rw = 1'b1; cpu_a15 = 1'b0;
    peek("coinc_cnt", 0, 0);
    peek("coinc_flags", 2, 2);
    sst_addr = 8'd0;
    low_falls(3); a12_rise(); peek("coinc_next_reload", 0, 5);

    // Reset during the A12-low phase
    cpu_wr(4, 5); low_falls(2);
    rst = 1'b1; tick(); rst = 1'b0;
    peek("rst_cnt", 0, 0);
    peek("rst_latch", 1, 0);
    peek("rst_flags", 2, 0);
    chk("rst_irq_n", int'(irq_n), 1);
    sst_addr = 8'd0;
    cpu_wr(4, 5); low_falls(1); a12_rise(); peek("rst_unqual", 0, 0);
    low_falls(3); a12_rise(); peek("rst_qual", 0, 5);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) != 0) cpu_m2 = ~cpu_m2;
      cpu_rw   = ($urandom_range(0, 2) != 0);
      cpu_a15  = ($urandom_range(0, 3) != 0);
      cpu_a14  = ($urandom_range(0, 4) != 0);
      cpu_a13  = 1'($urandom_range(0, 1));
      cpu_a0   = 1'($urandom_range(0, 1));
      cpu_data = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ppu_a12 = ~ppu_a12;
      sst_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
